des_perm_pipe: RTL

Parametrised, pipelined bit-permutation engine with a runtime-programmable permutation table and valid/ready handshakes on input and output. It replaces hard-wired single-permutation wiring in the DES datapath. At reset, with WIDTH=32, the table holds the DES P-box, so the block drops into the round function as-is. Each transaction applies the table either forward or inverse, chosen per transaction.

---
 rtl/des_perm_pipe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/des_perm_pipe.sv
`default_nettype none
// des_perm_pipe: two-stage runtime-programmable bit permutation, forward or inverse per word.
// Optional table bijection check enabled by defining DES_PERM_CHECK_EN.  Rev 1.0
module des_perm_pipe #(
   parameter int  WIDTH           = 32,
   parameter int  RESET_TABLE_DES = 1,
   localparam int IDXW            = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_inv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             cfg_we,
   input  logic [IDXW-1:0]  cfg_idx,
   input  logic [IDXW-1:0]  cfg_val,
   output logic             cfg_ready,
   output logic             perm_err
);
   localparam int DES_P [32] = '{16, 25, 12, 11,  3, 20,  4, 15, 31, 17,  9,  6, 27, 14,  1, 22,
                                 30, 24,  8, 18,  0,  5, 29, 23, 13, 19,  2, 26, 10, 21, 28,  7};

   logic [IDXW-1:0]  tab    [WIDTH];
   logic [IDXW-1:0]  tab_nx [WIDTH];
   logic             s1_v;
   logic [WIDTH-1:0] s1_data;
   logic             s1_inv;
   logic [WIDTH-1:0] perm;
   logic             s2_load;
   logic             s1_load;
   logic             accept;
   logic             cfg_wr;
   logic             blocked;

   // DES P is listed MSB-first, so list position k lands in entry 31-k.
   function automatic logic [IDXW-1:0] reset_entry(input int i);
      if (RESET_TABLE_DES != 0 && WIDTH == 32)
         return IDXW'(DES_P[31 - i]);
      return IDXW'(i);
   endfunction

   assign s2_load   = !out_valid || out_ready;
   assign s1_load   = s2_load || !s1_v;
   assign in_ready  = s1_load && !cfg_we && !blocked;
   assign accept    = in_valid && in_ready;
   assign cfg_ready = !s1_v && !out_valid;
   assign cfg_wr    = cfg_we && cfg_ready
                      && ({1'b0, cfg_idx} < (IDXW + 1)'(WIDTH))
                      && ({1'b0, cfg_val} < (IDXW + 1)'(WIDTH));

   always_comb begin
      for (int i = 0; i < WIDTH; i++)
         tab_nx[i] = tab[i];
      if (cfg_wr)
         tab_nx[cfg_idx] = cfg_val;
   end

   // Ascending loop: on inverse collisions the highest source index wins.
   always_comb begin
      perm = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (s1_inv)
            perm[tab[i]] = s1_data[i];
         else
            perm[i] = s1_data[tab[i]];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_data   <= '0;
         s1_inv    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < WIDTH; i++)
            tab[i] <= reset_entry(i);
      end else begin
         for (int i = 0; i < WIDTH; i++)
            tab[i] <= tab_nx[i];
         if (s1_load) begin
            s1_v <= accept;
            if (accept) begin
               s1_data <= in_data;
               s1_inv  <= in_inv;
            end
         end
         if (s2_load) begin
            out_valid <= s1_v;
            if (s1_v)
               out_data <= perm;
         end
      end
   end

`ifdef DES_PERM_CHECK_EN
   logic [WIDTH-1:0] seen;

   always_comb begin
      seen = '0;
      for (int i = 0; i < WIDTH; i++)
         seen[tab_nx[i]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         perm_err <= 1'b0;
      else if (cfg_wr)
         perm_err <= ~&seen;
   end

   assign blocked = perm_err;
`else
   assign perm_err = 1'b0;
   assign blocked  = 1'b0;
`endif

endmodule
`default_nettype wire
